// File: rtl/gate_response_checker.sv
// Self-test receiver for the two-input gate unit: accepts {in1,in2,res} vectors over valid/ready,
// recomputes the eight gate outputs, and tracks check/mismatch counts plus the first failure.
module gate_response_checker #(
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned CNT_W       = 8,
    parameter logic [7:0]  CHECK_MASK  = 8'hFF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_vec_valid,
    output logic             o_vec_ready,
    input  logic             i_vec_in1,
    input  logic             i_vec_in2,
    input  logic [7:0]       i_vec_res,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_chk_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_first_fail_valid,
    output logic [9:0]       o_first_fail_vec
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] NumVec  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_VECTORS - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_chk_count;
    logic [CNT_W-1:0] r_err_count;
    logic             r_s1_valid;
    logic [9:0]       r_s1_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_ff_valid;
    logic [9:0]       r_ff_vec;

    logic             w_vec_ready;
    logic             w_xfer;
    logic             w_a;
    logic             w_b;
    logic [7:0]       w_exp;
    logic             w_mismatch;
    logic             w_err_inc;
    logic [CNT_W-1:0] w_err_next;
    logic             w_last;

    always_comb begin
        w_vec_ready = (r_state == StRun) && (r_acc_cnt < NumVec);
        // start has priority: no transfer in a start cycle even though ready is high
        w_xfer      = i_vec_valid && w_vec_ready && !i_start;
        w_a         = r_s1_vec[9];
        w_b         = r_s1_vec[8];
        w_exp       = {~w_b, ~w_a, ~(w_a ^ w_b), ~(w_a | w_b), ~(w_a & w_b),
                       w_a ^ w_b, w_a | w_b, w_a & w_b};
        w_mismatch  = |((r_s1_vec[7:0] ^ w_exp) & CHECK_MASK);
        w_err_inc   = w_mismatch && (r_err_count != '1);
        w_err_next  = r_err_count + CNT_W'(w_err_inc);
        w_last      = r_s1_valid && (r_chk_count == LastIdx);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_acc_cnt   <= '0;
            r_chk_count <= '0;
            r_err_count <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_vec    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= '0;
        end else if (i_start) begin
            r_state     <= StRun;
            r_acc_cnt   <= '0;
            r_chk_count <= '0;
            r_err_count <= '0;
            r_s1_valid  <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= '0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_vec  <= {i_vec_in1, i_vec_in2, i_vec_res};
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
            if (r_s1_valid) begin
                r_chk_count <= r_chk_count + CNT_W'(1);
                r_err_count <= w_err_next;
                if (w_mismatch && !r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_vec   <= r_s1_vec;
                end
            end
            if (w_last) begin
                r_state <= StDone;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= (w_err_next == '0);
            end
        end
    end

    assign o_vec_ready        = w_vec_ready;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_pass             = r_pass;
    assign o_chk_count        = r_chk_count;
    assign o_err_count        = r_err_count;
    assign o_first_fail_valid = r_ff_valid;
    assign o_first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: the driver pushes expected results per accepted vector, the monitor pops
// and compares whenever the checker's count advances. Two instances cover masks FF and FE.
module tb_gate_response_checker;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          vec_valid = 1'b0;
    logic          in1 = 1'b0;
    logic          in2 = 1'b0;
    logic [7:0]    res = 8'h00;

    logic          a_ready, a_busy, a_done, a_pass, a_ffv;
    logic [CW-1:0] a_chk, a_err;
    logic [9:0]    a_ffvec;
    logic          b_ready, b_busy, b_done, b_pass, b_ffv;
    logic [CW-1:0] b_chk, b_err;
    logic [9:0]    b_ffvec;

    gate_response_checker #(.NUM_VECTORS(N), .CNT_W(CW), .CHECK_MASK(8'hFF)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_vec_valid(vec_valid),
        .o_vec_ready(a_ready), .i_vec_in1(in1), .i_vec_in2(in2), .i_vec_res(res),
        .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_chk_count(a_chk),
        .o_err_count(a_err), .o_first_fail_valid(a_ffv), .o_first_fail_vec(a_ffvec)
    );

    gate_response_checker #(.NUM_VECTORS(N), .CNT_W(CW), .CHECK_MASK(8'hFE)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_vec_valid(vec_valid),
        .o_vec_ready(b_ready), .i_vec_in1(in1), .i_vec_in2(in2), .i_vec_res(res),
        .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_chk_count(b_chk),
        .o_err_count(b_err), .o_first_fail_valid(b_ffv), .o_first_fail_vec(b_ffvec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         chk;
        int         err;
        int         err_b;
        logic       ffv;
        logic [9:0] ffvec;
        logic       ffv_b;
        logic [9:0] ffvec_b;
        logic       done;
        logic       pass;
        logic       pass_b;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: session bookkeeping from the rules, not the RTL's structure
    bit         m_open = 0;
    int         m_acc = 0, m_chk = 0, m_err = 0, m_err_b = 0;
    logic       m_ffv = 0, m_ffv_b = 0;
    logic [9:0] m_ffvec = 0, m_ffvec_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gate_ref(input logic a, input logic b);
        int x, y, s;
        x = int'(a);
        y = int'(b);
        s = x + y;
        gate_ref[0] = (s == 2);
        gate_ref[1] = (s >= 1);
        gate_ref[2] = (s == 1);
        gate_ref[3] = (s != 2);
        gate_ref[4] = (s == 0);
        gate_ref[5] = (s != 1);
        gate_ref[6] = (x == 0);
        gate_ref[7] = (y == 0);
    endfunction

    function automatic bit is_bad(input logic a, input logic b, input logic [7:0] r,
                                  input logic [7:0] mask);
        logic [7:0] g;
        g = gate_ref(a, b);
        for (int i = 0; i < 8; i++) begin
            if (mask[i] && (r[i] != g[i])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear(input bit open);
        q.delete();
        m_open = open;
        m_acc = 0; m_chk = 0; m_err = 0; m_err_b = 0;
        m_ffv = 0; m_ffv_b = 0; m_ffvec = '0; m_ffvec_b = '0;
    endtask

    // One clock of stimulus; entered and left at posedge+1
    task automatic cycle(input logic s, input logic v, input logic a, input logic b,
                         input logic [7:0] r);
        bit rdy;
        exp_t e;
        start = s; vec_valid = v; in1 = a; in2 = b; res = r;
        @(negedge clk);
        rdy = m_open && (m_acc < N);
        check("vec_ready", 32'(a_ready), 32'(rdy));
        check("vec_ready_b", 32'(b_ready), 32'(rdy));
        if (s) begin
            model_clear(1'b1);
        end else if (v && rdy) begin
            m_acc++;
            m_chk++;
            if (is_bad(a, b, r, 8'hFF)) begin
                if (m_err < 255) m_err++;
                if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = {a, b, r}; end
            end
            if (is_bad(a, b, r, 8'hFE)) begin
                if (m_err_b < 255) m_err_b++;
                if (!m_ffv_b) begin m_ffv_b = 1'b1; m_ffvec_b = {a, b, r}; end
            end
            e.due = cyc + 2;
            e.chk = m_chk; e.err = m_err; e.err_b = m_err_b;
            e.ffv = m_ffv; e.ffvec = m_ffvec; e.ffv_b = m_ffv_b; e.ffvec_b = m_ffvec_b;
            e.done = (m_chk == N);
            e.pass = (m_chk == N) && (m_err == 0);
            e.pass_b = (m_chk == N) && (m_err_b == 0);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0; vec_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(a_ready), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_pass", 32'(a_pass), 0);
        check("rst_chk", 32'(a_chk), 0);
        check("rst_err", 32'(a_err), 0);
        check("rst_ffv", 32'(a_ffv), 0);
        check("rst_ffvec", 32'(a_ffvec), 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear(1'b0);
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Bounded drain, then compare session-level status against the model
    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 8 && q.size() != 0; i++) idle(1);
        idle(1);
        check({tag, "_drain"}, 32'(q.size()), 0);
        check({tag, "_chk"}, 32'(a_chk), 32'(m_chk));
        check({tag, "_err"}, 32'(a_err), 32'(m_err));
        check({tag, "_done"}, 32'(a_done), 32'(m_chk == N));
        check({tag, "_busy"}, 32'(a_busy), 32'(m_open && m_chk != N));
        check({tag, "_pass"}, 32'(a_pass), 32'(m_chk == N && m_err == 0));
        check({tag, "_b_done"}, 32'(b_done), 32'(m_chk == N));
        check({tag, "_b_busy"}, 32'(b_busy), 32'(m_open && m_chk != N));
    endtask

    logic       g_in1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       g_in2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] g_res [4] = '{8'hF8, 8'h8E, 8'h4E, 8'h23};

    task automatic sweep(input int fault_idx, input logic [7:0] fault_res);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, g_in1[i], g_in2[i], (i == fault_idx) ? fault_res : g_res[i]);
    endtask

    // Monitor: one pop per advance of the checker's count
    logic [CW-1:0] prev_chk = '0;
    always begin
        exp_t e;
        @(posedge clk);
        #3;
        if (a_chk !== prev_chk && a_chk !== '0) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: chk_count=%0d with nothing expected", a_chk);
            end else begin
                e = q.pop_front();
                check("latency", 32'(cyc), 32'(e.due));
                check("chk_count", 32'(a_chk), 32'(e.chk));
                check("err_count", 32'(a_err), 32'(e.err));
                check("ff_valid", 32'(a_ffv), 32'(e.ffv));
                check("ff_vec", 32'(a_ffvec), 32'(e.ffvec));
                check("done", 32'(a_done), 32'(e.done));
                check("pass", 32'(a_pass), 32'(e.pass));
                check("b_chk_count", 32'(b_chk), 32'(e.chk));
                check("b_err_count", 32'(b_err), 32'(e.err_b));
                check("b_ff_valid", 32'(b_ffv), 32'(e.ffv_b));
                check("b_ff_vec", 32'(b_ffvec), 32'(e.ffvec_b));
                check("b_pass", 32'(b_pass), 32'(e.pass_b));
            end
        end
        prev_chk = a_chk;
    end

    initial begin
        logic a, b;
        logic [7:0] r;

        // Reset state, then valid in IDLE is ignored
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h8E);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hF8);
        idle(2);
        check("idle_chk", 32'(a_chk), 0);

        // Golden sweep
        sweep(-1, 8'h00);
        drain_and_check("golden");
        check("golden_pass", 32'(a_pass), 1);

        // Single fault in third vector; mask FE ignores it
        sweep(2, 8'h4F);
        drain_and_check("fault");
        check("fault_ffvec", 32'(a_ffvec), 32'h14F);
        check("fault_ffv", 32'(a_ffv), 1);
        check("fault_err", 32'(a_err), 1);
        check("mask_err", 32'(b_err), 0);
        check("mask_pass", 32'(b_pass), 1);

        // Gapped handshake plus surplus vectors after quota
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 200 && m_acc < N; i++) begin
            a = 1'($urandom); b = 1'($urandom);
            cycle(1'b0, ($urandom_range(0, 2) == 0), a, b, gate_ref(a, b));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h23);
        drain_and_check("gaps");
        check("gaps_ready", 32'(a_ready), 0);
        check("gaps_chk4", 32'(a_chk), 4);

        // Reset after two transfers, then a clean session
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hF8);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h8E);
        apply_reset();
        sweep(-1, 8'h00);
        drain_and_check("after_rst");
        check("after_rst_pass", 32'(a_pass), 1);

        // Restart mid-run: in-flight vector discarded, four more required
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h8E);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h4E);
        check("restart_chk", 32'(a_chk), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, g_in1[i], g_in2[i], g_res[i]);
        idle(2);
        check("restart_not_done", 32'(a_done), 0);
        cycle(1'b0, 1'b1, g_in1[3], g_in2[3], g_res[3]);
        drain_and_check("restart");

        // Randomised sessions with faults, gaps and occasional restarts
        for (int s = 0; s < 10; s++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            for (int i = 0; i < 300 && m_acc < N; i++) begin
                a = 1'($urandom); b = 1'($urandom);
                r = gate_ref(a, b);
                if ($urandom_range(0, 2) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
                cycle(($urandom_range(0, 30) == 0), ($urandom_range(0, 3) != 0), a, b, r);
            end
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
            drain_and_check("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
